// File: rtl/reel_gfx_pkg.sv
// rtl/reel_gfx_pkg.sv - shared sprite geometry, blitter state and address types
package reel_gfx_pkg;

    localparam int SPRITE_ROWS          = 64;
    localparam int SPRITE_WORDS_PER_ROW = 4;
    localparam int SPRITE_WORDS         = SPRITE_ROWS * SPRITE_WORDS_PER_ROW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } blit_state_t;

    typedef logic [13:0] fb_addr_t;

endpackage

// File: rtl/latency_pipe.sv
// rtl/latency_pipe.sv - fixed-depth shift pipe carrying a valid bit and a payload
//
// Ports:
//   clk, rst_n  clock, async active-low clear (valid bits only)
//   in_valid    valid pushed into stage 0
//   in_data     payload pushed into stage 0
//   out_valid   valid at the last stage (DEPTH cycles after push)
//   out_data    payload at the last stage
//   valid_vec   all stage valids, bit DEPTH-1 is the output stage
module latency_pipe #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [DEPTH-1:0] valid_vec
);

    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] dat [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else begin
            vld[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    // Payload is never reset: it is only observed when its valid bit is set.
    always_ff @(posedge clk) begin
        dat[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) begin
            dat[i] <= dat[i-1];
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];
    assign valid_vec = vld;

endmodule

// File: rtl/reel_blitter.sv
// rtl/reel_blitter.sv - copies a 64x64 1bpp reel sprite from ROM into the framebuffer
//
// Optional build macro: REEL_BLITTER_INVERT_EN adds the invert input.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   start        one-cycle blit request, sampled only when idle
//   dst_base     framebuffer word address of the sprite's top-left word
//   scroll       source row rotation 0..63
//   invert       (macro only) latched at start, inverts all written data
//   busy         high while a blit is in progress
//   done         pulses with the final framebuffer write
//   rom_addr     sprite ROM address {src_row, col}
//   rom_data     ROM data, valid ROM_LATENCY cycles after rom_addr
//   fb_wr_en     framebuffer write enable
//   fb_addr      framebuffer word address
//   fb_din       framebuffer write data
module reel_blitter
    import reel_gfx_pkg::*;
#(
    parameter int ROM_LATENCY  = 2,
    parameter int FB_ADDR_W    = 14,
    parameter int FB_ROW_WORDS = 40
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [FB_ADDR_W-1:0] dst_base,
    input  logic [5:0]           scroll,
`ifdef REEL_BLITTER_INVERT_EN
    input  logic                 invert,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           rom_addr,
    input  logic [15:0]          rom_data,
    output logic                 fb_wr_en,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [15:0]          fb_din
);

    localparam logic [ROM_LATENCY-1:0] LAST_STAGE = ROM_LATENCY'(1) << (ROM_LATENCY - 1);

    blit_state_t          state, state_nxt;
    logic [5:0]           row, scroll_q;
    logic [1:0]           col;
    logic [FB_ADDR_W-1:0] base_q, row_base;
    logic                 inv_q;
    logic                 last_issue;
    logic                 pipe_out_valid;
    logic [FB_ADDR_W-1:0] pipe_out_addr;
    logic [ROM_LATENCY-1:0] pipe_vld;
    logic                 pipe_last_word;
    logic [5:0]           src_row;

    assign last_issue     = (row == 6'd63) && (col == 2'd3);
    // Only the output stage is occupied: this is the final write of the blit.
    assign pipe_last_word = pipe_out_valid && ((pipe_vld & ~LAST_STAGE) == '0);
    assign src_row        = row + scroll_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)          state_nxt = FETCH;
            FETCH:   if (last_issue)     state_nxt = DRAIN;
            DRAIN:   if (pipe_last_word) state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    // Counters freeze on the last issue so rom_addr holds during DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row      <= '0;
            col      <= '0;
            row_base <= '0;
            base_q   <= '0;
            scroll_q <= '0;
            inv_q    <= 1'b0;
        end else if (state == IDLE && start) begin
            row      <= '0;
            col      <= '0;
            row_base <= '0;
            base_q   <= dst_base;
            scroll_q <= scroll;
`ifdef REEL_BLITTER_INVERT_EN
            inv_q    <= invert;
`else
            inv_q    <= 1'b0;
`endif
        end else if (state == FETCH && !last_issue) begin
            col <= col + 2'd1;
            if (col == 2'd3) begin
                row      <= row + 6'd1;
                row_base <= row_base + FB_ADDR_W'(FB_ROW_WORDS);
            end
        end
    end

    latency_pipe #(
        .DEPTH (ROM_LATENCY),
        .WIDTH (FB_ADDR_W)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (state == FETCH),
        .in_data   (base_q + row_base + FB_ADDR_W'(col)),
        .out_valid (pipe_out_valid),
        .out_data  (pipe_out_addr),
        .valid_vec (pipe_vld)
    );

    always_comb begin
        busy     = (state != IDLE);
        done     = (state == DRAIN) && pipe_last_word;
        rom_addr = {src_row, col};
        fb_wr_en = pipe_out_valid;
        fb_addr  = pipe_out_valid ? pipe_out_addr : '0;
        fb_din   = pipe_out_valid ? (rom_data ^ {16{inv_q}}) : 16'h0000;
    end

endmodule

// File: tb/tb_reel_blitter.sv
// tb/tb_reel_blitter.sv - scoreboard bench for reel_blitter
module tb_reel_blitter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [13:0] dst_base;
    logic [5:0]  scroll;
`ifdef REEL_BLITTER_INVERT_EN
    logic        invert;
`endif
    logic        busy, done;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        fb_wr_en;
    logic [13:0] fb_addr;
    logic [15:0] fb_din;

    always #5 clk = ~clk;

    reel_blitter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dst_base (dst_base),
        .scroll   (scroll),
`ifdef REEL_BLITTER_INVERT_EN
        .invert   (invert),
`endif
        .busy     (busy),
        .done     (done),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .fb_wr_en (fb_wr_en),
        .fb_addr  (fb_addr),
        .fb_din   (fb_din)
    );

    // Double-registered sync ROM: two cycles from address to data.
    logic [15:0] rom_mem [256];
    logic [15:0] rom_r1;
    always @(posedge clk) begin
        rom_r1   <= rom_mem[rom_addr];
        rom_data <= rom_r1;
    end

    typedef struct {
        logic [13:0] addr;
        logic [15:0] data;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   stray      = 0;
    bit   sb_en      = 1'b1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic push_blit(input logic [13:0] base, input logic [5:0] scr, input logic inv);
        exp_t e;
        for (int r = 0; r < 64; r++) begin
            for (int c = 0; c < 4; c++) begin
                logic [5:0] sr;
                sr     = 6'(r) + scr;
                e.addr = base + 14'(40 * r + c);
                e.data = rom_mem[{sr, 2'(c)}] ^ {16{inv}};
                e.last = (r == 63) && (c == 3);
                exp_q.push_back(e);
            end
        end
    endtask

    // Monitor: compares every write against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done && !fb_wr_en) check("done_without_write", 32'(done), 32'd0);
            if (fb_wr_en) begin
                if (!sb_en) begin
                    stray++;
                end else if (exp_q.size() == 0) begin
                    check("unexpected_write_addr", 32'(fb_addr), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("fb_addr", 32'(fb_addr), 32'(e.addr));
                    check("fb_din", 32'(fb_din), 32'(e.data));
                    check("done", 32'(done), 32'(e.last));
                end
            end
        end
    end

    task automatic run_blit(input logic [13:0] base, input logic [5:0] scr, input logic inv,
                            input int restart_at);
        int n;
        push_blit(base, scr, inv);
        @(posedge clk); #1;
        dst_base = base;
        scroll   = scr;
`ifdef REEL_BLITTER_INVERT_EN
        invert   = inv;
`endif
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dst_base = ~base;
        scroll   = ~scr;
`ifdef REEL_BLITTER_INVERT_EN
        invert   = ~inv;
`endif
        n = 0;
        @(negedge clk);
        while (busy && n < 1000) begin
            n++;
            if (n == restart_at) begin
                start    = 1'b1;
                dst_base = 14'h1234;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_cycles", 32'(n), 32'd258);
        repeat (3) @(negedge clk);
        check("busy_stays_low", 32'(busy), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 256; k++) rom_mem[k] = 16'h1000 + 16'(k);
        rst_n    = 1'b0;
        start    = 1'b0;
        dst_base = '0;
        scroll   = '0;
`ifdef REEL_BLITTER_INVERT_EN
        invert   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fb_wr_en", 32'(fb_wr_en), 32'd0);
        check("rst_fb_addr", 32'(fb_addr), 32'd0);
        check("rst_fb_din", 32'(fb_din), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_blit(14'h0000, 6'd0, 1'b0, 0);      // basic
        run_blit(14'h0064, 6'd63, 1'b0, 0);     // scroll 63: first word ROM[252]
        run_blit(14'h3FFE, 6'd0, 1'b0, 0);      // address wrap
        run_blit(14'h0200, 6'd17, 1'b0, 100);   // start while busy ignored
        run_blit(14'h0010, 6'd5, 1'b0, 258);    // start in the done cycle ignored

        // Reset mid-blit
        sb_en = 1'b0;
        @(posedge clk); #1;
        dst_base = 14'h0300;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_fb_wr_en", 32'(fb_wr_en), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        stray = 0;
        repeat (300) @(negedge clk);
        check("writes_after_reset", 32'(stray), 32'd0);
        check("busy_after_reset", 32'(busy), 32'd0);
        sb_en = 1'b1;

        run_blit(14'h0007, 6'd5, 1'b0, 0);      // recovers after reset

`ifdef REEL_BLITTER_INVERT_EN
        for (int k = 0; k < 256; k++) rom_mem[k] = 16'h00FF;
        run_blit(14'h0000, 6'd0, 1'b1, 0);      // expects FF00
        run_blit(14'h0000, 6'd0, 1'b0, 0);      // expects 00FF
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
